// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC ownership, synchronous imem interface,
// single-entry skid buffer for the one-cycle read latency, and redirect handling.
// Optional feature macro: FETCH_HALT_EN (adds halt/halted ports, sticky halt).
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] f_pc,
   output logic [31:0] f_inst,
   output logic        f_valid,
   output logic [1:0]  fd_update
`ifdef FETCH_HALT_EN
   ,
   input  logic        halt,
   output logic        halted
`endif
);

   localparam logic [1:0] FD_HOLD  = 2'b00;
   localparam logic [1:0] FD_LOAD  = 2'b01;
   localparam logic [1:0] FD_FLUSH = 2'b10;

   logic [31:0] pc_q;
   logic        rsp_valid;
   logic [31:0] rsp_pc;
   logic        skid_valid;
   logic [31:0] skid_pc;
   logic [31:0] skid_inst;

   logic        halt_now;
   logic        issue;
   logic        skid_cap;
   logic        skid_clr;
   logic [31:0] target_addr;
   logic [31:0] pres_pc;
   logic [31:0] pres_inst;

`ifdef FETCH_HALT_EN
   logic halted_q;

   // Halt is sticky: once seen at an edge it holds until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_q <= 1'b0;
      end else if (halt) begin
         halted_q <= 1'b1;
      end
   end

   // A halt request takes effect in its own cycle, ahead of any redirect.
   assign halt_now = halt | halted_q;
   assign halted   = halted_q & ~rst;
`else
   assign halt_now = 1'b0;
`endif

   // Issue decision, imem request, presented instruction and update code.
   always_comb begin
      target_addr = {redirect_pc[31:2], 2'b00};
      issue       = !rst && !halt_now && (redirect || !stall);
      imem_en     = issue;
      imem_addr   = redirect ? target_addr : pc_q;

      // Skid entry is older than the response arriving now, so it goes first.
      pres_pc     = skid_valid ? skid_pc   : rsp_pc;
      pres_inst   = skid_valid ? skid_inst : imem_rdata;

      // Wrong-path data is never shown during a redirect cycle.
      f_valid     = !rst && !halt_now && !redirect && (skid_valid || rsp_valid);
      f_pc        = f_valid ? pres_pc   : 32'h0;
      f_inst      = f_valid ? pres_inst : 32'h0;

      if (rst || halt_now || redirect) begin
         fd_update = FD_FLUSH;
      end else if (stall) begin
         fd_update = FD_HOLD;
      end else if (f_valid) begin
         fd_update = FD_LOAD;
      end else begin
         fd_update = FD_FLUSH;
      end

      // Only one read can be outstanding while stalled, so one entry suffices.
      skid_cap    = !rst && !halt_now && !redirect && stall && rsp_valid && !skid_valid;
      skid_clr    = halt_now || redirect || (skid_valid && fd_update == FD_LOAD);
   end

   // Control state: PC, response-in-flight flag and skid occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         rsp_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (issue) begin
            pc_q      <= imem_addr + 32'd4;
            rsp_valid <= 1'b1;
         end else begin
            rsp_valid <= 1'b0;
         end

         if (skid_clr) begin
            skid_valid <= 1'b0;
         end else if (skid_cap) begin
            skid_valid <= 1'b1;
         end
      end
   end

   // Data payloads are qualified by the control flags and need no reset.
   always_ff @(posedge clk) begin
      if (issue) begin
         rsp_pc <= imem_addr;
      end
      if (skid_cap) begin
         skid_pc   <= rsp_pc;
         skid_inst <= imem_rdata;
      end
   end

endmodule
